axi_config_regfile: RTL and testbench
=====================================

// Module: axi_config_regfile
// PURPOSE
//  Register bank directly downstream of the AXI config-write bridge.
//  - Consumes its single-cycle write strobe bus (wr/waddr/wdata/wstrb) into NUM_REGS word registers.
//  - Drives the registers as flat configuration outputs.
//  - Provides a 1-cycle-latency read port for a read bridge or debug.
//  - Supports read-only status words, self-clearing pulse words, and a saturating error counter.
// PARAMETERS
//  ADDR_WIDTH  32      byte address width of waddr/raddr
//  DATA_WIDTH  32      register/word width in bits
//  STRB_WIDTH  DATA_WIDTH/8  byte lanes per word; word stride = STRB_WIDTH bytes
//  NUM_REGS    16      number of words (>=1); IDX_W = max(1,$clog2(NUM_REGS))
//  BASE_ADDR   0       byte address of word 0; must be STRB_WIDTH-aligned
//  RO_MASK     0       bit i=1: word i is read-only; reads return status_in word i
//  PULSE_MASK  0       bit i=1: word i is self-clearing (bits high one cycle only)
// PORTS
//  clk           in   1                       clock, all logic rising-edge
//  rst_n         in   1                       synchronous active-low reset
//  wr            in   1                       write strobe, one word per asserted cycle
//  waddr         in   ADDR_WIDTH              write byte address
//  wdata         in   DATA_WIDTH              write data
//  wstrb         in   STRB_WIDTH              byte enables for wdata
//  rd            in   1                       read request, one per asserted cycle
//  raddr         in   ADDR_WIDTH              read byte address
//  rdata         out  DATA_WIDTH              read data, valid with rvalid
//  rvalid        out  1                       read response valid, one-cycle pulse
//  rerr          out  1                       read address out of range, qualifies rvalid
//  wr_err        out  1                       one-cycle pulse: last write was out of range or to a RO word
//  err_count     out  8                       saturating count of rejected writes
//  status_in     in   NUM_REGS*DATA_WIDTH     status words for RO_MASK entries (word i at [i*DATA_WIDTH +: DATA_WIDTH])
//  cfg_out       out  NUM_REGS*DATA_WIDTH     register contents, same packing; RO words drive 0
// BEHAVIOUR
//  Clock and reset
//  - One clock. Reset is synchronous, active-low, sampled on the clk edge with rst_n==0.
//  - Reset values: all cfg_out, rdata, rvalid, rerr, wr_err and err_count are 0.
//  Address decode (identical for both ports)
//  - off = addr - BASE_ADDR; idx = off >> log2(STRB_WIDTH).
//  - Low log2(STRB_WIDTH) address bits are ignored.
//  - In range iff addr >= BASE_ADDR and idx < NUM_REGS.
//  Writes
//  - Writable word: on the edge where wr==1, byte b of word idx takes wdata byte b iff wstrb[b].
//  - cfg_out reflects the write the cycle after wr (1-cycle latency). wstrb==0 is a legal no-op, not an error.
//  - Consecutive wr cycles (burst from the bridge) are each applied; no back-pressure exists.
//  - Pulse words: written bits appear on cfg_out for exactly one cycle, then clear to 0.
//    Back-to-back writes to a pulse word keep the written bits high on each following cycle.
//  - RO word or out of range: no state change; wr_err=1 next cycle; err_count+1, saturating at 8'hFF.
//  Reads
//  - rd==1 gives rvalid=1 on the next cycle.
//  - rdata: register value (RO word: status_in sampled at the rd cycle). Out of range: rdata=0 and rerr=1.
//  - rvalid/rerr/wr_err are single-cycle pulses; rdata holds its last value when rvalid==0.
//  Simultaneous events
//  - wr and rd to the same word in one cycle: the read returns the pre-write value.
//  - A pulse-word read returns the value currently on cfg_out.
//  - wr and rd are independent; both may be active every cycle.
//  Reset mid-operation
//  - rst_n low in the same cycle as wr/rd: the write is dropped, no rvalid is produced, and reset values win.
// TESTING
//  1. Reset then idle: rst_n=0 two cycles -> cfg_out=0, rvalid=0, err_count=0.
//  2. wr waddr=BASE+8 wdata=32'hA5A5_1234 wstrb=4'b0101, then rd raddr=BASE+8
//     -> word2=32'h00A5_0034; rvalid 1 cycle after rd; rdata=32'h00A5_0034.
//  3. PULSE_MASK bit3: wr word3 wdata=32'h1 -> cfg_out word3=1 for exactly 1 cycle, then 0.
//  4. RO_MASK bit1, status_in word1=32'hDEAD_BEEF: wr word1 -> wr_err pulse, err_count=1;
//     rd word1 -> rdata=32'hDEAD_BEEF.
//  5. Out of range: wr and rd at BASE+4*NUM_REGS -> wr_err=1, rerr=1, rdata=0.
//     300 bad writes -> err_count=8'hFF.
//  6. Same-cycle wr/rd to word0 (old 0, new 32'h5) -> rdata=0; next read returns 32'h5.
//     Additionally, wr concurrent with rst_n=0 -> word stays 0.

Source files
------------

// File: rtl/axi_config_regfile.sv
// Config register bank fed by the AXI write bridge: byte-strobed writes, flat
// cfg outputs, a 1-cycle read port, RO status words, pulse words and an error counter.
module axi_config_regfile #(
   parameter int                     ADDR_WIDTH = 32,
   parameter int                     DATA_WIDTH = 32,
   parameter int                     STRB_WIDTH = DATA_WIDTH / 8,
   parameter int                     NUM_REGS   = 16,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = {ADDR_WIDTH{1'b0}},
   parameter logic [NUM_REGS-1:0]    RO_MASK    = {NUM_REGS{1'b0}},
   parameter logic [NUM_REGS-1:0]    PULSE_MASK = {NUM_REGS{1'b0}}
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr,
   input  logic [ADDR_WIDTH-1:0]          waddr,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [STRB_WIDTH-1:0]          wstrb,
   input  logic                           rd,
   input  logic [ADDR_WIDTH-1:0]          raddr,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic                           rvalid,
   output logic                           rerr,
   output logic                           wr_err,
   output logic [7:0]                     err_count,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
   output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_out
);

   localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int LANE_SHIFT = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
   localparam logic [DATA_WIDTH-1:0] ZERO_WORD = {DATA_WIDTH{1'b0}};

   // {in_range, word index}; byte-lane bits below the word stride are dropped
   function automatic logic [IDX_W:0] decode(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] word;
      word = (addr - BASE_ADDR) >> LANE_SHIFT;
      return {(addr >= BASE_ADDR) && (word < ADDR_WIDTH'(NUM_REGS)), word[IDX_W-1:0]};
   endfunction

   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [STRB_WIDTH-1:0] strb
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_word;
      for (int b = 0; b < STRB_WIDTH; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
         else         res[b*8 +: 8] = old_word[b*8 +: 8];
      end
      return res;
   endfunction

   logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
   logic [DATA_WIDTH-1:0] rdata_r;
   logic                  rvalid_r;
   logic                  rerr_r;
   logic                  wr_err_r;
   logic [7:0]            err_count_r;

   logic                  win_s, rin_s;
   logic [IDX_W-1:0]      widx_s, ridx_s;
   logic                  wr_ok_s, wr_bad_s;
   logic [DATA_WIDTH-1:0] rword_s;

   assign {win_s, widx_s} = decode(waddr);
   assign {rin_s, ridx_s} = decode(raddr);

   // Classify the current write as accepted or rejected
   always_comb begin
      wr_ok_s  = 1'b0;
      wr_bad_s = 1'b0;
      if (wr) begin
         if (win_s && !RO_MASK[widx_s]) wr_ok_s  = 1'b1;
         else                           wr_bad_s = 1'b1;
      end else begin
         wr_ok_s  = 1'b0;
         wr_bad_s = 1'b0;
      end
   end

   // Read mux: RO words expose live status, others the pre-write register value
   always_comb begin
      rword_s = ZERO_WORD;
      if (rin_s) begin
         if (RO_MASK[ridx_s]) rword_s = status_in[ridx_s*DATA_WIDTH +: DATA_WIDTH];
         else                 rword_s = regs_r[ridx_s];
      end else begin
         rword_s = ZERO_WORD;
      end
   end

   // Register storage, pulse-word clearing and write-error accounting
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= ZERO_WORD;
         wr_err_r    <= 1'b0;
         err_count_r <= 8'h00;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (PULSE_MASK[i]) regs_r[i] <= ZERO_WORD;
         end
         // A pulse word merges onto zero so only the bytes written this cycle show
         if (wr_ok_s) begin
            regs_r[widx_s] <= merge_bytes(PULSE_MASK[widx_s] ? ZERO_WORD : regs_r[widx_s],
                                          wdata, wstrb);
         end
         wr_err_r <= wr_bad_s;
         if (wr_bad_s && (err_count_r != 8'hFF)) err_count_r <= err_count_r + 8'h01;
      end
   end

   // Read response pipeline; rdata holds between responses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_r  <= ZERO_WORD;
         rvalid_r <= 1'b0;
         rerr_r   <= 1'b0;
      end else begin
         rvalid_r <= rd;
         rerr_r   <= rd && !rin_s;
         if (rd) rdata_r <= rword_s;
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_REGS; g++) begin : g_cfg
         assign cfg_out[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? ZERO_WORD : regs_r[g];
      end
   endgenerate

   assign rdata     = rdata_r;
   assign rvalid    = rvalid_r;
   assign rerr      = rerr_r;
   assign wr_err    = wr_err_r;
   assign err_count = err_count_r;

endmodule

// File: tb/tb_axi_config_regfile.sv
// Self-checking bench for axi_config_regfile: a vector table with hard-coded
// expectations, a read scoreboard queue, and hand-written reset/saturation sequences.
module tb_axi_config_regfile;

   localparam int NR = 16;
   localparam logic [31:0] BASE = 32'h0000_0100;

   logic              clk;
   logic              rst_n;
   logic              wr;
   logic [31:0]       waddr;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              rd;
   logic [31:0]       raddr;
   logic [31:0]       rdata;
   logic              rvalid;
   logic              rerr;
   logic              wr_err;
   logic [7:0]        err_count;
   logic [NR*32-1:0]  status_in;
   logic [NR*32-1:0]  cfg_out;

   axi_config_regfile #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .NUM_REGS(NR),
      .BASE_ADDR(BASE), .RO_MASK(16'h0002), .PULSE_MASK(16'h0008)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr(wr), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
      .rd(rd), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .rerr(rerr),
      .wr_err(wr_err), .err_count(err_count), .status_in(status_in), .cfg_out(cfg_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        rd;
      logic [31:0] raddr;
      logic [31:0] exp_rdata;
      logic        exp_rerr;
      logic        exp_wr_err;
      int          cfg_idx;
      logic [31:0] exp_cfg;
      logic [7:0]  exp_ec;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } rsp_t;

   rsp_t sb[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Drive one cycle, then compare everything the vector promises
   task automatic apply(input vec_t v);
      rsp_t r;
      wr = v.wr; waddr = v.waddr; wdata = v.wdata; wstrb = v.wstrb;
      rd = v.rd; raddr = v.raddr;
      if (v.rd) begin
         r.data = v.exp_rdata;
         r.err  = v.exp_rerr;
         sb.push_back(r);
      end
      @(posedge clk); #1;
      if (sb.size() > 0) begin
         r = sb.pop_front();
         check("rvalid", {31'd0, rvalid}, 32'd1);
         check("rdata", rdata, r.data);
         check("rerr", {31'd0, rerr}, {31'd0, r.err});
      end else begin
         check("rvalid_idle", {31'd0, rvalid}, 32'd0);
      end
      check("wr_err", {31'd0, wr_err}, {31'd0, v.exp_wr_err});
      check("err_count", {24'd0, err_count}, {24'd0, v.exp_ec});
      check($sformatf("cfg%0d", v.cfg_idx), cfg_out[v.cfg_idx*32 +: 32], v.exp_cfg);
   endtask

   vec_t tbl [16];
   vec_t v;

   initial begin
      // wr waddr wdata strb rd raddr exp_rdata rerr wr_err cfg_idx exp_cfg ec
      tbl[0]  = '{1'b1, BASE+32'h08, 32'hA5A5_1234, 4'b0101, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2, 32'h00A5_0034, 8'd0};
      tbl[1]  = '{1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, BASE+32'h08, 32'h00A5_0034, 1'b0, 1'b0, 2, 32'h00A5_0034, 8'd0};
      tbl[2]  = '{1'b1, BASE+32'h0C, 32'h0000_0001, 4'b1111, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3, 32'h0000_0001, 8'd0};
      tbl[3]  = '{1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3, 32'h0000_0000, 8'd0};
      tbl[4]  = '{1'b1, BASE+32'h04, 32'h1234_5678, 4'b1111, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1, 32'h0000_0000, 8'd1};
      tbl[5]  = '{1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, BASE+32'h04, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, 32'h0000_0000, 8'd1};
      tbl[6]  = '{1'b1, BASE+32'h40, 32'hFFFF_FFFF, 4'b1111, 1'b1, BASE+32'h40, 32'h0, 1'b1, 1'b1, 2, 32'h00A5_0034, 8'd2};
      tbl[7]  = '{1'b1, BASE-32'h04, 32'hFFFF_FFFF, 4'b1111, 1'b1, BASE-32'h04, 32'h0, 1'b1, 1'b1, 15, 32'h0000_0000, 8'd3};
      tbl[8]  = '{1'b1, BASE, 32'h0000_0005, 4'b1111, 1'b1, BASE, 32'h0000_0000, 1'b0, 1'b0, 0, 32'h0000_0005, 8'd3};
      tbl[9]  = '{1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, BASE+32'h01, 32'h0000_0005, 1'b0, 1'b0, 0, 32'h0000_0005, 8'd3};
      tbl[10] = '{1'b1, BASE+32'h08, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2, 32'h00A5_0034, 8'd3};
      tbl[11] = '{1'b1, BASE+32'h08, 32'h1122_3344, 4'b1010, 1'b1, BASE+32'h3C, 32'h0, 1'b0, 1'b0, 2, 32'h11A5_3334, 8'd3};
      tbl[12] = '{1'b1, BASE+32'h0C, 32'h0000_00F0, 4'b1111, 1'b1, BASE+32'h0C, 32'h0, 1'b0, 1'b0, 3, 32'h0000_00F0, 8'd3};
      tbl[13] = '{1'b1, BASE+32'h0C, 32'h0000_000F, 4'b1111, 1'b1, BASE+32'h0C, 32'h0000_00F0, 1'b0, 1'b0, 3, 32'h0000_000F, 8'd3};
      tbl[14] = '{1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, BASE+32'h0C, 32'h0000_000F, 1'b0, 1'b0, 3, 32'h0000_0000, 8'd3};
      tbl[15] = '{1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3, 32'h0000_0000, 8'd3};

      for (int i = 0; i < NR; i++) status_in[i*32 +: 32] = 32'hCAFE_0000 | i;
      status_in[1*32 +: 32] = 32'hDEAD_BEEF;

      rst_n = 1'b0; wr = 1'b0; waddr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
      rd = 1'b0; raddr = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cfg_zero", {31'd0, (cfg_out == '0)}, 32'd1);
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_rerr", {31'd0, rerr}, 32'd0);
      check("rst_wr_err", {31'd0, wr_err}, 32'd0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_err_count", {24'd0, err_count}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) apply(tbl[i]);
      check("rdata_hold", rdata, 32'h0000_000F);

      // Rejected-write counter must climb from 3 and stick at 8'hFF
      for (int i = 0; i < 300; i++) begin
         v = tbl[7];
         v.rd = 1'b0;
         v.exp_ec = (3 + i + 1 > 255) ? 8'hFF : 8'(3 + i + 1);
         apply(v);
      end
      check("err_sat", {24'd0, err_count}, 32'h0000_00FF);

      // Reset in the same cycle as a write and a read: reset wins
      rst_n = 1'b0;
      wr = 1'b1; waddr = BASE + 32'h10; wdata = 32'h0000_0005; wstrb = 4'hF;
      rd = 1'b1; raddr = BASE + 32'h10;
      @(posedge clk); #1;
      check("midrst_rvalid", {31'd0, rvalid}, 32'd0);
      check("midrst_cfg_zero", {31'd0, (cfg_out == '0)}, 32'd1);
      check("midrst_err_count", {24'd0, err_count}, 32'd0);
      check("midrst_wr_err", {31'd0, wr_err}, 32'd0);
      rst_n = 1'b1; wr = 1'b0; rd = 1'b0;
      @(posedge clk); #1;
      check("midrst_word4", cfg_out[4*32 +: 32], 32'h0);
      check("midrst_rvalid2", {31'd0, rvalid}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
